// File: rtl/endp_addr_codec_pkg.sv
// Shared topology enum, defaults and derived-width helpers for the endpoint address codec.
package endp_addr_codec_pkg;

  typedef enum logic [1:0] {
    TOPO_MESH  = 2'd0,
    TOPO_TORUS = 2'd1,
    TOPO_LINE  = 2'd2,
    TOPO_RING  = 2'd3
  } topo_e;

  localparam int NX_DEF = 4;
  localparam int NY_DEF = 4;
  localparam int NL_DEF = 1;

  // One-dimensional topologies collapse to a single row.
  function automatic int ny_eff(topo_e t, int ny);
    if (t == TOPO_LINE || t == TOPO_RING) return 1;
    else return ny;
  endfunction

  function automatic int max1_clog2(int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int ne_f(topo_e t, int nx, int ny, int nl);
    return nx * ny_eff(t, ny) * nl;
  endfunction

  function automatic int new_f(topo_e t, int nx, int ny, int nl);
    return max1_clog2(ne_f(t, nx, ny, nl));
  endfunction

  function automatic int xw_f(int nx);
    return max1_clog2(nx);
  endfunction

  function automatic int yw_f(topo_e t, int ny);
    return (ny_eff(t, ny) > 1) ? $clog2(ny_eff(t, ny)) : 0;
  endfunction

  function automatic int lw_f(int nl);
    return (nl > 1) ? $clog2(nl) : 0;
  endfunction

  function automatic int eaw_f(topo_e t, int nx, int ny, int nl);
    return xw_f(nx) + yw_f(t, ny) + lw_f(nl);
  endfunction

endpackage

// File: rtl/endp_addr_codec_map.sv
// Combinational id<->{l,y,x} mapping with range checks; all arithmetic is by elaboration constants.
module endp_addr_map
  import endp_addr_codec_pkg::*;
#(
  parameter topo_e TOPOLOGY = TOPO_MESH,
  parameter int NX = NX_DEF,
  parameter int NY = NY_DEF,
  parameter int NL = NL_DEF,
  localparam int NEW = new_f(TOPOLOGY, NX, NY, NL),
  localparam int EAW = eaw_f(TOPOLOGY, NX, NY, NL)
) (
  input  logic           enc_valid,
  input  logic [NEW-1:0] enc_id,
  output logic [EAW-1:0] enc_code,
  output logic           enc_err,
  input  logic           dec_valid,
  input  logic [EAW-1:0] dec_code,
  output logic [NEW-1:0] dec_id,
  output logic           dec_err
);

  localparam int NYE = ny_eff(TOPOLOGY, NY);
  localparam int NE  = ne_f(TOPOLOGY, NX, NY, NL);
  localparam int XW  = xw_f(NX);
  localparam int YW  = yw_f(TOPOLOGY, NY);

  logic [31:0] enc_id_s, enc_r_s, enc_x_s, enc_y_s, enc_l_s;
  logic [31:0] dec_w_s, dec_x_s, dec_y_s, dec_l_s;

  // Encode: split id into router index and local slot, then router into x/y.
  always_comb begin
    enc_id_s = 32'(enc_id);
    enc_l_s  = enc_id_s % NL;
    enc_r_s  = enc_id_s / NL;
    enc_x_s  = enc_r_s % NX;
    enc_y_s  = enc_r_s / NX;
    if (enc_id_s >= NE) begin
      enc_err  = enc_valid;
      enc_code = {EAW{1'b0}};
    end else begin
      enc_err  = 1'b0;
      enc_code = EAW'(enc_x_s | (enc_y_s << XW) | (enc_l_s << (XW + YW)));
    end
  end

  // Decode: absent fields mask to zero, so they can never trip the range check.
  always_comb begin
    dec_w_s = 32'(dec_code);
    dec_x_s = dec_w_s & ((32'd1 << XW) - 32'd1);
    dec_y_s = (dec_w_s >> XW) & ((32'd1 << YW) - 32'd1);
    dec_l_s = dec_w_s >> (XW + YW);
    if (dec_x_s >= NX || dec_y_s >= NYE || dec_l_s >= NL) begin
      dec_err = dec_valid;
      dec_id  = {NEW{1'b0}};
    end else begin
      dec_err = 1'b0;
      dec_id  = NEW'((dec_y_s * NX + dec_x_s) * NL + dec_l_s);
    end
  end

endmodule

// File: rtl/endp_addr_codec.sv
// Endpoint address codec top: mapping core plus optional one-cycle output registers per direction.
module endp_addr_codec
  import endp_addr_codec_pkg::*;
#(
  parameter topo_e TOPOLOGY = TOPO_MESH,
  parameter int NX = NX_DEF,
  parameter int NY = NY_DEF,
  parameter int NL = NL_DEF,
  parameter int REGISTERED = 1,
  localparam int NEW = new_f(TOPOLOGY, NX, NY, NL),
  localparam int EAW = eaw_f(TOPOLOGY, NX, NY, NL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enc_valid_in,
  input  logic [NEW-1:0] enc_id_in,
  output logic           enc_valid_out,
  output logic [EAW-1:0] enc_code_out,
  output logic           enc_err,
  input  logic           dec_valid_in,
  input  logic [EAW-1:0] dec_code_in,
  output logic           dec_valid_out,
  output logic [NEW-1:0] dec_id_out,
  output logic           dec_err
);

  logic [EAW-1:0] enc_code_s;
  logic           enc_err_s;
  logic [NEW-1:0] dec_id_s;
  logic           dec_err_s;

  endp_addr_map #(.TOPOLOGY(TOPOLOGY), .NX(NX), .NY(NY), .NL(NL)) u_map (
    .enc_valid (enc_valid_in),
    .enc_id    (enc_id_in),
    .enc_code  (enc_code_s),
    .enc_err   (enc_err_s),
    .dec_valid (dec_valid_in),
    .dec_code  (dec_code_in),
    .dec_id    (dec_id_s),
    .dec_err   (dec_err_s)
  );

  if (REGISTERED != 0) begin : g_reg
    logic           enc_valid_r, enc_err_r, dec_valid_r, dec_err_r;
    logic [EAW-1:0] enc_code_r;
    logic [NEW-1:0] dec_id_r;

    // Output registers; data and error hold their last value between valid requests.
    always_ff @(posedge clk) begin
      if (!reset) begin
        enc_valid_r <= 1'b0;
        enc_code_r  <= {EAW{1'b0}};
        enc_err_r   <= 1'b0;
        dec_valid_r <= 1'b0;
        dec_id_r    <= {NEW{1'b0}};
        dec_err_r   <= 1'b0;
      end else begin
        enc_valid_r <= enc_valid_in;
        dec_valid_r <= dec_valid_in;
        if (enc_valid_in) begin
          enc_code_r <= enc_code_s;
          enc_err_r  <= enc_err_s;
        end
        if (dec_valid_in) begin
          dec_id_r  <= dec_id_s;
          dec_err_r <= dec_err_s;
        end
      end
    end

    assign enc_valid_out = enc_valid_r;
    assign enc_code_out  = enc_code_r;
    assign enc_err       = enc_err_r;
    assign dec_valid_out = dec_valid_r;
    assign dec_id_out    = dec_id_r;
    assign dec_err       = dec_err_r;
  end else begin : g_comb
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ reset;
    assign enc_valid_out = enc_valid_in;
    assign enc_code_out  = enc_code_s;
    assign enc_err       = enc_err_s;
    assign dec_valid_out = dec_valid_in;
    assign dec_id_out    = dec_id_s;
    assign dec_err       = dec_err_s;
  end

endmodule

// File: tb/tb_endp_addr_codec.sv
// Self-checking bench: three codec configurations checked against an arithmetic/search reference model.
module tb_endp_addr_codec;
  import endp_addr_codec_pkg::*;

  logic clk_s = 1'b0;
  logic reset_s;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_s = ~clk_s;

  // A: MESH 4x4x2 registered (NEw=5, EAw=5)
  logic a_ev_s, a_evo_s, a_eerr_s, a_dv_s, a_dvo_s, a_derr_s;
  logic [4:0] a_eid_s, a_ecode_s, a_dcode_s, a_did_s;
  // B: MESH 3x3x1 registered (NEw=4, EAw=4)
  logic b_ev_s, b_evo_s, b_eerr_s, b_dv_s, b_dvo_s, b_derr_s;
  logic [3:0] b_eid_s, b_ecode_s, b_dcode_s, b_did_s;
  // C: LINE 8 combinational (NEw=3, EAw=3)
  logic c_ev_s, c_evo_s, c_eerr_s, c_dv_s, c_dvo_s, c_derr_s;
  logic [2:0] c_eid_s, c_ecode_s, c_dcode_s, c_did_s;

  endp_addr_codec #(.TOPOLOGY(TOPO_MESH), .NX(4), .NY(4), .NL(2), .REGISTERED(1)) u_a (
    .clk(clk_s), .reset(reset_s),
    .enc_valid_in(a_ev_s), .enc_id_in(a_eid_s), .enc_valid_out(a_evo_s),
    .enc_code_out(a_ecode_s), .enc_err(a_eerr_s),
    .dec_valid_in(a_dv_s), .dec_code_in(a_dcode_s), .dec_valid_out(a_dvo_s),
    .dec_id_out(a_did_s), .dec_err(a_derr_s));

  endp_addr_codec #(.TOPOLOGY(TOPO_MESH), .NX(3), .NY(3), .NL(1), .REGISTERED(1)) u_b (
    .clk(clk_s), .reset(reset_s),
    .enc_valid_in(b_ev_s), .enc_id_in(b_eid_s), .enc_valid_out(b_evo_s),
    .enc_code_out(b_ecode_s), .enc_err(b_eerr_s),
    .dec_valid_in(b_dv_s), .dec_code_in(b_dcode_s), .dec_valid_out(b_dvo_s),
    .dec_id_out(b_did_s), .dec_err(b_derr_s));

  endp_addr_codec #(.TOPOLOGY(TOPO_LINE), .NX(8), .NY(4), .NL(1), .REGISTERED(0)) u_c (
    .clk(clk_s), .reset(reset_s),
    .enc_valid_in(c_ev_s), .enc_id_in(c_eid_s), .enc_valid_out(c_evo_s),
    .enc_code_out(c_ecode_s), .enc_err(c_eerr_s),
    .dec_valid_in(c_dv_s), .dec_code_in(c_dcode_s), .dec_valid_out(c_dvo_s),
    .dec_id_out(c_did_s), .dec_err(c_derr_s));

  // Reference encode straight from the field definitions; returns 0 for out-of-range ids.
  function automatic int m_enc(int id, int nx, int nl, int ne, int xw, int yw);
    int r, l, x, y;
    if (id >= ne) return 0;
    r = id / nl;
    l = id % nl;
    x = r % nx;
    y = r / nx;
    return x + y * (1 << xw) + l * (1 << (xw + yw));
  endfunction

  // Reference decode by searching for the id whose encoding matches; -1 means no such id.
  function automatic int m_dec(int code, int nx, int nl, int ne, int xw, int yw);
    for (int i = 0; i < ne; i++)
      if (m_enc(i, nx, nl, ne, xw, yw) == code) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic test_reset();
    reset_s = 1'b0;
    a_ev_s = 1'b1; a_eid_s = 5'd13; a_dv_s = 1'b1; a_dcode_s = 5'h16;
    b_ev_s = 1'b1; b_eid_s = 4'd12; b_dv_s = 1'b1; b_dcode_s = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({a_evo_s, a_ecode_s, a_eerr_s, a_dvo_s, a_did_s, a_derr_s} !== 14'd0) begin
        n_err++;
        $display("FAIL reset_a cyc%0d got %h want 0", i,
                 {a_evo_s, a_ecode_s, a_eerr_s, a_dvo_s, a_did_s, a_derr_s});
      end
      n_cmp++;
      if ({b_evo_s, b_ecode_s, b_eerr_s, b_dvo_s, b_did_s, b_derr_s} !== 12'd0) begin
        n_err++;
        $display("FAIL reset_b cyc%0d got %h want 0", i,
                 {b_evo_s, b_ecode_s, b_eerr_s, b_dvo_s, b_did_s, b_derr_s});
      end
    end
    reset_s = 1'b1;
    a_ev_s = 1'b0; a_dv_s = 1'b0; b_ev_s = 1'b0; b_dv_s = 1'b0;
    tick();
    n_cmp++;
    if ({a_evo_s, a_dvo_s, b_evo_s, b_dvo_s} !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release_valid got %b want 0000", {a_evo_s, a_dvo_s, b_evo_s, b_dvo_s});
    end
  endtask

  task automatic test_enc_known();
    a_ev_s = 1'b1; a_eid_s = 5'd13;
    #1;
    n_cmp++;
    if (a_evo_s !== 1'b0) begin
      n_err++; $display("FAIL enc13_early_valid got %b want 0", a_evo_s);
    end
    tick();
    n_cmp++;
    if ({a_evo_s, a_ecode_s, a_eerr_s} !== {1'b1, 5'h16, 1'b0}) begin
      n_err++;
      $display("FAIL enc13 got v=%b code=%h err=%b want v=1 code=16 err=0", a_evo_s, a_ecode_s, a_eerr_s);
    end
    a_ev_s = 1'b0; a_eid_s = 5'd2;
    tick();
    n_cmp++;
    if ({a_evo_s, a_ecode_s, a_eerr_s} !== {1'b0, 5'h16, 1'b0}) begin
      n_err++;
      $display("FAIL enc13_hold got v=%b code=%h err=%b want v=0 code=16 err=0", a_evo_s, a_ecode_s, a_eerr_s);
    end
  endtask

  task automatic test_dec_known();
    a_dv_s = 1'b1; a_dcode_s = 5'h16;
    tick();
    a_dv_s = 1'b0;
    n_cmp++;
    if ({a_dvo_s, a_did_s, a_derr_s} !== {1'b1, 5'd13, 1'b0}) begin
      n_err++;
      $display("FAIL dec16 got v=%b id=%0d err=%b want v=1 id=13 err=0", a_dvo_s, a_did_s, a_derr_s);
    end
  endtask

  task automatic test_roundtrip_a();
    int ec, dc;
    logic [4:0] code_q [$];
    for (int i = 0; i < 32; i++) begin
      ec = m_enc(i, 4, 2, 32, 2, 2);
      a_ev_s = 1'b1; a_eid_s = 5'(i); a_dv_s = 1'b0;
      tick();
      n_cmp++;
      if ({a_ecode_s, a_eerr_s} !== {5'(ec), 1'b0}) begin
        n_err++; $display("FAIL rt_enc id%0d got %h/%b want %h/0", i, a_ecode_s, a_eerr_s, ec);
      end
      code_q.push_back(a_ecode_s);
    end
    a_ev_s = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a_dv_s = 1'b1; a_dcode_s = code_q.pop_front();
      tick();
      dc = i;
      n_cmp++;
      if ({a_did_s, a_derr_s} !== {5'(dc), 1'b0}) begin
        n_err++; $display("FAIL rt_dec id%0d got %0d/%b want %0d/0", i, a_did_s, a_derr_s, dc);
      end
    end
    a_dv_s = 1'b0;
  endtask

  task automatic test_range_b();
    int ec, dc;
    for (int i = 0; i < 16; i++) begin
      ec = m_enc(i, 3, 1, 9, 2, 2);
      b_ev_s = 1'b1; b_eid_s = 4'(i);
      b_dv_s = 1'b1; b_dcode_s = 4'(i);
      tick();
      n_cmp++;
      if ({b_evo_s, b_ecode_s, b_eerr_s} !== {1'b1, 4'(ec), (i >= 9)}) begin
        n_err++;
        $display("FAIL b_enc id%0d got v=%b code=%b err=%b want code=%b err=%b",
                 i, b_evo_s, b_ecode_s, b_eerr_s, 4'(ec), (i >= 9));
      end
      dc = m_dec(i, 3, 1, 9, 2, 2);
      n_cmp++;
      if ({b_dvo_s, b_did_s, b_derr_s} !== {1'b1, 4'((dc < 0) ? 0 : dc), (dc < 0)}) begin
        n_err++;
        $display("FAIL b_dec code%b got v=%b id=%0d err=%b want id=%0d err=%b",
                 4'(i), b_dvo_s, b_did_s, b_derr_s, (dc < 0) ? 0 : dc, (dc < 0));
      end
    end
    b_ev_s = 1'b0; b_dv_s = 1'b0;
  endtask

  task automatic test_random_registered();
    int ec, dc;
    int a_code_h = 0, a_id_h = 0, b_code_h = 0, b_id_h = 0;
    logic b_eerr_h = 1'b0, b_derr_h = 1'b0;
    logic av, adv, bv, bdv;
    for (int i = 0; i < 200; i++) begin
      av  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      adv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bv  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bdv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a_ev_s = av;  a_eid_s   = 5'($urandom_range(0, 31));
      a_dv_s = adv; a_dcode_s = 5'($urandom_range(0, 31));
      b_ev_s = bv;  b_eid_s   = 4'($urandom_range(0, 15));
      b_dv_s = bdv; b_dcode_s = 4'($urandom_range(0, 15));
      if (av) a_code_h = m_enc(int'(a_eid_s), 4, 2, 32, 2, 2);
      if (adv) a_id_h = m_dec(int'(a_dcode_s), 4, 2, 32, 2, 2);
      if (bv) begin
        b_code_h = m_enc(int'(b_eid_s), 3, 1, 9, 2, 2);
        b_eerr_h = (b_eid_s >= 4'd9);
      end
      if (bdv) begin
        dc = m_dec(int'(b_dcode_s), 3, 1, 9, 2, 2);
        b_derr_h = (dc < 0);
        b_id_h = (dc < 0) ? 0 : dc;
      end
      tick();
      ec = a_code_h;
      n_cmp++;
      if ({a_evo_s, a_ecode_s, a_eerr_s, a_dvo_s, a_did_s, a_derr_s} !==
          {av, 5'(ec), 1'b0, adv, 5'(a_id_h), 1'b0}) begin
        n_err++;
        $display("FAIL rand_a it%0d got v=%b c=%h e=%b dv=%b id=%0d de=%b want v=%b c=%h dv=%b id=%0d",
                 i, a_evo_s, a_ecode_s, a_eerr_s, a_dvo_s, a_did_s, a_derr_s, av, 5'(ec), adv, a_id_h);
      end
      n_cmp++;
      if ({b_evo_s, b_ecode_s, b_eerr_s, b_dvo_s, b_did_s, b_derr_s} !==
          {bv, 4'(b_code_h), b_eerr_h, bdv, 4'(b_id_h), b_derr_h}) begin
        n_err++;
        $display("FAIL rand_b it%0d got v=%b c=%b e=%b dv=%b id=%0d de=%b want v=%b c=%b e=%b dv=%b id=%0d de=%b",
                 i, b_evo_s, b_ecode_s, b_eerr_s, b_dvo_s, b_did_s, b_derr_s,
                 bv, 4'(b_code_h), b_eerr_h, bdv, 4'(b_id_h), b_derr_h);
      end
    end
    a_ev_s = 1'b0; a_dv_s = 1'b0; b_ev_s = 1'b0; b_dv_s = 1'b0;
  endtask

  task automatic test_reset_midstream();
    a_ev_s = 1'b1; a_eid_s = 5'd3; a_dv_s = 1'b1; a_dcode_s = 5'h16;
    tick();
    a_eid_s = 5'd4; reset_s = 1'b0;
    tick();
    n_cmp++;
    if ({a_evo_s, a_ecode_s, a_eerr_s, a_dvo_s, a_did_s, a_derr_s} !== 14'd0) begin
      n_err++;
      $display("FAIL midreset got %h want 0", {a_evo_s, a_ecode_s, a_eerr_s, a_dvo_s, a_did_s, a_derr_s});
    end
    reset_s = 1'b1; a_ev_s = 1'b0; a_dv_s = 1'b0;
    tick();
    n_cmp++;
    if ({a_evo_s, a_dvo_s, a_ecode_s} !== 7'd0) begin
      n_err++;
      $display("FAIL midreset_stale got v=%b dv=%b code=%h want 0", a_evo_s, a_dvo_s, a_ecode_s);
    end
  endtask

  task automatic test_back_to_back_comb();
    int ec, dc;
    logic v, dv;
    c_ev_s = 1'b1; c_eid_s = 3'd7; c_dv_s = 1'b0; c_dcode_s = 3'd0;
    #1;
    n_cmp++;
    if ({c_evo_s, c_ecode_s, c_eerr_s} !== {1'b1, 3'b111, 1'b0}) begin
      n_err++;
      $display("FAIL c_enc7 got v=%b code=%b err=%b want 1/111/0", c_evo_s, c_ecode_s, c_eerr_s);
    end
    for (int i = 0; i < 40; i++) begin
      v  = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      c_ev_s = v;  c_eid_s   = 3'($urandom_range(0, 7));
      c_dv_s = dv; c_dcode_s = 3'($urandom_range(0, 7));
      #2;
      ec = m_enc(int'(c_eid_s), 8, 1, 8, 3, 0);
      dc = m_dec(int'(c_dcode_s), 8, 1, 8, 3, 0);
      n_cmp++;
      if ({c_evo_s, c_ecode_s, c_eerr_s, c_dvo_s, c_did_s, c_derr_s} !==
          {v, 3'(ec), 1'b0, dv, 3'((dc < 0) ? 0 : dc), (dc < 0)}) begin
        n_err++;
        $display("FAIL c_b2b it%0d got v=%b c=%b e=%b dv=%b id=%0d de=%b want v=%b c=%b dv=%b id=%0d",
                 i, c_evo_s, c_ecode_s, c_eerr_s, c_dvo_s, c_did_s, c_derr_s, v, 3'(ec), dv, dc);
      end
    end
  endtask

  initial begin
    c_ev_s = 1'b0; c_eid_s = 3'd0; c_dv_s = 1'b0; c_dcode_s = 3'd0;
    test_reset();
    test_enc_known();
    test_dec_known();
    test_roundtrip_a();
    test_range_b();
    test_random_registered();
    test_reset_midstream();
    test_back_to_back_comb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
